sys_ctrl_burst: RTL and testbench
=================================

# sys_ctrl_burst

Parametrised command controller, successor to the single-byte system controller. It runs in the REF_CLK domain between the RX data synchronizer, the register file, the gated ALU and the TX async FIFO write port. It decodes framed UART command bytes and drives the register file, the ALU and the TX FIFO. Over the previous generation it adds generic data and address widths, burst register read and write commands, an error pulse for unknown opcodes, and an optional frame timeout.

## Interface
- DATA_WIDTH, 8, command, data and register width
- ADDR_WIDTH, 4, register file address width
- TIMEOUT_CYCLES, 1024, idle cycles before a partial frame is aborted (used only with timeout compiled in)
- CLK  in  1  REF_CLK domain clock
- RST  in  1  reset, asynchronous and active-high
- RX_P_DATA  in  DATA_WIDTH  synchronized received byte
- RX_D_VLD  in  1  one-cycle strobe qualifying RX_P_DATA
- Rd_D  in  DATA_WIDTH  register file read data
- Rd_D_Vld  in  1  read data valid
- ALU_OUT  in  2*DATA_WIDTH  ALU result
- OUT_Valid  in  1  ALU result valid
- FIFO_Full  in  1  TX FIFO full
- ALU_FUN  out  4  ALU function
- EN  out  1  ALU enable strobe
- CLK_EN  out  1  ALU clock-gate enable
- Address  out  ADDR_WIDTH  register address
- WrEn  out  1  register write strobe
- RdEn  out  1  register read strobe
- WrData  out  DATA_WIDTH  register write data
- TX_P_DATA  out  DATA_WIDTH  FIFO write data
- TX_D_VLD  out  1  FIFO write strobe
- clk_div_en  out  1  UART clock divider enable
- cmd_error  out  1  one-cycle pulse on an unknown opcode or a timeout abort
- busy  out  1  high whenever the FSM is not IDLE

## Operation
- Opcodes are compared on the low 8 bits; upper bits are ignored when DATA_WIDTH > 8.
  - 0xAA, write: addr, data.
  - 0xBB, read: addr.
  - 0xCC, ALU with operands: A, B, fun.
  - 0xDD, ALU without operands: fun.
  - 0xEE, burst write: addr, N, then N data bytes.
  - 0xEF, burst read: addr, N.
- States: IDLE, GET_ADDR, GET_CNT, GET_DATA, WRITE, RD_REQ, RD_WAIT, TX_PUSH, GET_OPA, GET_OPB, GET_FUN, ALU_RUN, ALU_WAIT, TX_LO, TX_HI.
- The FSM advances only on RX_D_VLD while collecting bytes; bytes arriving in non-collecting states are dropped.
- An unknown opcode in IDLE raises cmd_error for 1 cycle; the FSM stays in IDLE.
- Operand A is written to address 0 and B to address 1, each via one WrEn cycle.
- Burst address is the low ADDR_WIDTH bits of the addr byte and increments after each transfer, wrapping modulo 2^ADDR_WIDTH.
- Burst count N = 0 ends the frame with no transfer and no error.
- Read path: RdEn for 1 cycle, then wait for Rd_D_Vld and latch Rd_D. In TX_PUSH, TX_D_VLD is asserted for 1 cycle once FIFO_Full is low. The FIFO is never written while FIFO_Full is high.
- ALU result is sent as the low DATA_WIDTH bits, then the high bits, each gated by FIFO_Full.
- clk_div_en is held at 1 outside reset.

## Timing
- Reset values: every output 0, except clk_div_en = 0 during reset and 1 from the first clock after release.
- Reset mid-frame discards the frame; no strobes are issued after release.
- Write: WrEn, Address and WrData are valid in the cycle after the data-byte strobe, exactly 1 cycle.
- Read: RdEn follows the addr strobe by 1 cycle. TX_D_VLD follows Rd_D_Vld by 1 cycle when FIFO_Full is low.
- ALU: CLK_EN rises on entry to ALU_RUN and stays high until the cycle after OUT_Valid.
  - EN is high for exactly 1 cycle, one cycle after CLK_EN rises.
  - ALU_FUN is held from the fun-byte strobe until IDLE.
  - ALU_OUT is captured on OUT_Valid.
- Burst read: one RdEn per word, never overlapping; the next RdEn issues the cycle after the previous TX_D_VLD.
- Simultaneous RX_D_VLD and a pending FIFO push: the push takes priority and the byte is dropped.
- Strobes EN, WrEn, RdEn, TX_D_VLD and cmd_error are registered outputs.

## Configuration
- Macro SYS_CTRL_TIMEOUT_EN.
- Defined: a counter clears on every RX_D_VLD and counts while in any GET_* state. When it reaches TIMEOUT_CYCLES, the frame is aborted: return to IDLE and pulse cmd_error for 1 cycle.
- Undefined: no counter is built; the FSM waits indefinitely for bytes.

## Test plan
- Write then read: 0xAA,0x05,0x3C then 0xBB,0x05 -> WrEn with Address=5, WrData=0x3C; later TX_D_VLD with TX_P_DATA=0x3C.
- ALU op: 0xCC,0x07,0x03,0x00 (add) -> writes reg0=7 and reg1=3, EN pulse, FIFO receives 0x0A then 0x00.
- Burst with wrap: 0xEE,0x0E,0x03,0x11,0x22,0x33 -> writes address 14=0x11, 15=0x22, 0=0x33; 0xEF,0x0E,0x03 -> FIFO receives 0x11,0x22,0x33.
- Backpressure: FIFO_Full held high for 20 cycles during a read -> no TX_D_VLD; a single push in the cycle after FIFO_Full falls.
- Error and timeout: opcode 0x55 -> cmd_error 1 cycle, busy stays 0. With SYS_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, send 0xAA and stop -> cmd_error on cycle 16, FSM in IDLE.

Source files
------------

// File: rtl/sys_ctrl_burst.sv
// Framed UART command controller with burst register read/write, ALU sequencing and TX FIFO push.
// Optional frame timeout is compiled in with `define SYS_CTRL_TIMEOUT_EN.
module sys_ctrl_burst #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]     Rd_D,
    input  logic                      Rd_D_Vld,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      OUT_Valid,
    input  logic                      FIFO_Full,
    output logic [3:0]                ALU_FUN,
    output logic                      EN,
    output logic                      CLK_EN,
    output logic [ADDR_WIDTH-1:0]     Address,
    output logic                      WrEn,
    output logic                      RdEn,
    output logic [DATA_WIDTH-1:0]     WrData,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    output logic                      clk_div_en,
    output logic                      cmd_error,
    output logic                      busy
);

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_CNT, GET_DATA, WRITE, RD_REQ, RD_WAIT, TX_PUSH,
        GET_OPA, GET_OPB, GET_FUN, ALU_RUN, ALU_WAIT, TX_LO, TX_HI
    } state_t;

    localparam logic [7:0] OP_WR   = 8'hAA;
    localparam logic [7:0] OP_RD   = 8'hBB;
    localparam logic [7:0] OP_ALU  = 8'hCC;
    localparam logic [7:0] OP_ALUN = 8'hDD;
    localparam logic [7:0] OP_BWR  = 8'hEE;
    localparam logic [7:0] OP_BRD  = 8'hEF;

    state_t                  state_q, state_d;
    logic [7:0]              op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   wrdata_q, wrdata_d;
    logic [DATA_WIDTH-1:0]   txdata_q, txdata_d;
    logic [3:0]              fun_q, fun_d;
    logic                    en_q, en_d, wren_q, wren_d, rden_q, rden_d;
    logic                    txvld_q, txvld_d, err_q, err_d, clken_q, clken_d;
    logic                    clkdiv_q, clkdiv_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [2*DATA_WIDTH-1:0] res_q, res_d;

    logic [7:0]            rx_op;
    logic [ADDR_WIDTH-1:0] rx_addr;
    logic                  collecting;

    assign rx_op      = RX_P_DATA[7:0];
    assign rx_addr    = RX_P_DATA[ADDR_WIDTH-1:0];
    assign collecting = state_q inside {GET_ADDR, GET_CNT, GET_DATA, GET_OPA, GET_OPB, GET_FUN};

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        wrdata_d = wrdata_q;
        txdata_d = txdata_q;
        fun_d    = fun_q;
        rdata_d  = rdata_q;
        res_d    = res_q;
        clken_d  = clken_q;
        en_d     = 1'b0;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        txvld_d  = 1'b0;
        err_d    = 1'b0;
        clkdiv_d = 1'b1;

        case (state_q)
            IDLE: begin
                fun_d = '0;
                if (RX_D_VLD) begin
                    op_d  = rx_op;
                    cnt_d = DATA_WIDTH'(1);
                    case (rx_op)
                        OP_WR, OP_RD, OP_BWR, OP_BRD: state_d = GET_ADDR;
                        OP_ALU:                       state_d = GET_OPA;
                        OP_ALUN:                      state_d = GET_FUN;
                        default:                      err_d   = 1'b1;
                    endcase
                end
            end
            GET_ADDR: if (RX_D_VLD) begin
                addr_d = rx_addr;
                if (op_q == OP_BWR || op_q == OP_BRD) begin
                    state_d = GET_CNT;
                end else if (op_q == OP_RD) begin
                    state_d = RD_REQ;
                    rden_d  = 1'b1;
                end else begin
                    state_d = GET_DATA;
                end
            end
            GET_CNT: if (RX_D_VLD) begin
                if (RX_P_DATA == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = RX_P_DATA;
                    if (op_q == OP_BRD) begin
                        state_d = RD_REQ;
                        rden_d  = 1'b1;
                    end else begin
                        state_d = GET_DATA;
                    end
                end
            end
            GET_DATA: if (RX_D_VLD) begin
                wrdata_d = RX_P_DATA;
                wren_d   = 1'b1;
                state_d  = WRITE;
            end
            GET_OPA: if (RX_D_VLD) begin
                addr_d   = '0;
                wrdata_d = RX_P_DATA;
                wren_d   = 1'b1;
                state_d  = WRITE;
            end
            GET_OPB: if (RX_D_VLD) begin
                addr_d   = ADDR_WIDTH'(1);
                wrdata_d = RX_P_DATA;
                wren_d   = 1'b1;
                state_d  = WRITE;
            end
            WRITE: begin
                // WrEn is high in this cycle; operand writes chain to the next operand.
                if (op_q == OP_ALU) begin
                    state_d = (addr_q == '0) ? GET_OPB : GET_FUN;
                end else if (cnt_q == DATA_WIDTH'(1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    addr_d  = addr_q + 1'b1;
                    state_d = GET_DATA;
                end
            end
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: if (Rd_D_Vld) begin
                rdata_d = Rd_D;
                state_d = TX_PUSH;
                if (!FIFO_Full) begin
                    txvld_d  = 1'b1;
                    txdata_d = Rd_D;
                end
            end
            TX_PUSH: begin
                if (txvld_q) begin
                    if (cnt_q == DATA_WIDTH'(1)) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        addr_d  = addr_q + 1'b1;
                        rden_d  = 1'b1;
                        state_d = RD_REQ;
                    end
                end else if (!FIFO_Full) begin
                    txvld_d  = 1'b1;
                    txdata_d = rdata_q;
                end
            end
            GET_FUN: if (RX_D_VLD) begin
                fun_d   = RX_P_DATA[3:0];
                clken_d = 1'b1;
                state_d = ALU_RUN;
            end
            ALU_RUN: begin
                en_d    = 1'b1;
                state_d = ALU_WAIT;
            end
            ALU_WAIT: if (OUT_Valid) begin
                res_d   = ALU_OUT;
                clken_d = 1'b0;
                state_d = TX_LO;
            end
            TX_LO: begin
                if (txvld_q) begin
                    state_d = TX_HI;
                end else if (!FIFO_Full) begin
                    txvld_d  = 1'b1;
                    txdata_d = res_q[DATA_WIDTH-1:0];
                end
            end
            TX_HI: begin
                if (txvld_q) begin
                    state_d = IDLE;
                end else if (!FIFO_Full) begin
                    txvld_d  = 1'b1;
                    txdata_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SYS_CTRL_TIMEOUT_EN
        tmo_d = '0;
        if (collecting && !RX_D_VLD) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
                tmo_d   = '0;
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            wrdata_q <= '0;
            txdata_q <= '0;
            fun_q    <= '0;
            en_q     <= 1'b0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            txvld_q  <= 1'b0;
            err_q    <= 1'b0;
            clken_q  <= 1'b0;
            clkdiv_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            wrdata_q <= wrdata_d;
            txdata_q <= txdata_d;
            fun_q    <= fun_d;
            en_q     <= en_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            txvld_q  <= txvld_d;
            err_q    <= err_d;
            clken_q  <= clken_d;
            clkdiv_q <= clkdiv_d;
        end
    end

    // Captured read word and ALU result are only consumed after being loaded.
    always_ff @(posedge CLK) begin
        rdata_q <= rdata_d;
        res_q   <= res_d;
    end

`ifdef SYS_CTRL_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`endif

    assign ALU_FUN    = fun_q;
    assign EN         = en_q;
    assign CLK_EN     = clken_q;
    assign Address    = addr_q;
    assign WrEn       = wren_q;
    assign RdEn       = rden_q;
    assign WrData     = wrdata_q;
    assign TX_P_DATA  = txdata_q;
    assign TX_D_VLD   = txvld_q;
    assign clk_div_en = clkdiv_q;
    assign cmd_error  = err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Directed bench for sys_ctrl_burst with register-file and ALU responders.
// The timeout section runs only when SYS_CTRL_TIMEOUT_EN is defined.
module tb_sys_ctrl_burst;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 16;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [DW-1:0]  RX_P_DATA;
    logic           RX_D_VLD;
    logic [DW-1:0]  Rd_D = '0;
    logic           Rd_D_Vld = 1'b0;
    logic [2*DW-1:0] ALU_OUT = '0;
    logic           OUT_Valid = 1'b0;
    logic           FIFO_Full;
    logic [3:0]     ALU_FUN;
    logic           EN, CLK_EN, WrEn, RdEn, TX_D_VLD, clk_div_en, cmd_error, busy;
    logic [AW-1:0]  Address;
    logic [DW-1:0]  WrData, TX_P_DATA;

    sys_ctrl_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .Rd_D(Rd_D), .Rd_D_Vld(Rd_D_Vld), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
        .FIFO_Full(FIFO_Full), .ALU_FUN(ALU_FUN), .EN(EN), .CLK_EN(CLK_EN),
        .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .clk_div_en(clk_div_en),
        .cmd_error(cmd_error), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Register file answers a read one cycle later; ALU answers EN one cycle later.
    logic [7:0] mem [16];
    always @(posedge CLK) begin
        Rd_D_Vld  <= RdEn;
        if (RdEn) Rd_D <= mem[Address];
        if (WrEn) mem[Address] <= WrData;
        OUT_Valid <= EN;
        if (EN) ALU_OUT <= (ALU_FUN == 4'd0) ? 16'(mem[0]) + 16'(mem[1])
                                             : 16'(mem[0]) * 16'(mem[1]);
    end

    int wr_cyc[$], wr_adr[$], wr_dat[$], rd_cyc[$], tx_cyc[$], tx_dat[$];
    int en_cyc[$], en_fun[$], err_cyc[$], cke_rise[$], cke_fall[$];
    int full_viol = 0;
    int busy_cycles = 0;
    logic cke_prev = 1'b0;

    always @(negedge CLK) begin
        if (!RST) begin
            if (WrEn) begin
                wr_cyc.push_back(cyc); wr_adr.push_back(int'(Address)); wr_dat.push_back(int'(WrData));
            end
            if (RdEn) rd_cyc.push_back(cyc);
            if (TX_D_VLD) begin
                tx_cyc.push_back(cyc); tx_dat.push_back(int'(TX_P_DATA));
                if (FIFO_Full) full_viol = full_viol + 1;
            end
            if (EN) begin
                en_cyc.push_back(cyc); en_fun.push_back(int'(ALU_FUN));
            end
            if (cmd_error) err_cyc.push_back(cyc);
            if (CLK_EN && !cke_prev) cke_rise.push_back(cyc);
            if (!CLK_EN && cke_prev) cke_fall.push_back(cyc);
            if (busy) busy_cycles = busy_cycles + 1;
        end
        cke_prev = CLK_EN;
    end

    int vectors = 0;
    int miscompares = 0;
    int last_stb = 0;
    int stb = 0;
    int t_rel = 0;

    task automatic check(input string tag, input int obs, input int exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_logs();
        wr_cyc.delete(); wr_adr.delete(); wr_dat.delete(); rd_cyc.delete();
        tx_cyc.delete(); tx_dat.delete(); en_cyc.delete(); en_fun.delete();
        err_cyc.delete(); cke_rise.delete(); cke_fall.delete();
        busy_cycles = 0;
    endtask

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        last_stb  = cyc;
        @(posedge CLK); #1;
        RX_D_VLD  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && busy; i++) begin
            @(posedge CLK); #1;
        end
        repeat (2) @(posedge CLK);
        #1;
        check(tag, int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RX_P_DATA = '0; RX_D_VLD = 1'b0; FIFO_Full = 1'b0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_strobes", int'({EN, WrEn, RdEn, TX_D_VLD, cmd_error, CLK_EN, busy}), 0);
        check("rst_clk_div_en", int'(clk_div_en), 0);
        check("rst_data_outs", int'({Address, WrData, TX_P_DATA, ALU_FUN}), 0);
        RST = 1'b0;
        @(posedge CLK); #1;
        check("clk_div_en_after_rst", int'(clk_div_en), 1);

        // single write
        clear_logs();
        send(8'hAA); send(8'h05); stb = last_stb; send(8'h3C);
        stb = last_stb;
        wait_idle("wr_idle");
        check("wr_count", wr_cyc.size(), 1);
        check("wr_addr", at(wr_adr, 0), 5);
        check("wr_data", at(wr_dat, 0), 'h3C);
        check("wr_latency", at(wr_cyc, 0), stb + 1);

        // single read
        clear_logs();
        send(8'hBB); send(8'h05);
        stb = last_stb;
        wait_idle("rd_idle");
        check("rd_count", rd_cyc.size(), 1);
        check("rd_latency", at(rd_cyc, 0), stb + 1);
        check("rd_tx_count", tx_cyc.size(), 1);
        check("rd_tx_data", at(tx_dat, 0), 'h3C);
        check("rd_tx_latency", at(tx_cyc, 0), at(rd_cyc, 0) + 2);

        // ALU with operands, add
        clear_logs();
        send(8'hCC); send(8'h07); send(8'h03); send(8'h00);
        stb = last_stb;
        wait_idle("alu_idle");
        check("alu_wr_count", wr_cyc.size(), 2);
        check("alu_opa", at(wr_adr, 0) * 256 + at(wr_dat, 0), 'h0007);
        check("alu_opb", at(wr_adr, 1) * 256 + at(wr_dat, 1), 'h0103);
        check("alu_en_count", en_cyc.size(), 1);
        check("alu_clken_rise", at(cke_rise, 0), stb + 1);
        check("alu_en_after_clken", at(en_cyc, 0), at(cke_rise, 0) + 1);
        check("alu_clken_fall", at(cke_fall, 0), at(en_cyc, 0) + 2);
        check("alu_fun_add", at(en_fun, 0), 0);
        check("alu_tx_count", tx_cyc.size(), 2);
        check("alu_tx_lo", at(tx_dat, 0), 'h0A);
        check("alu_tx_hi", at(tx_dat, 1), 'h00);

        // ALU without operands, multiply of stored 7 and 3
        clear_logs();
        send(8'hDD); send(8'h02);
        wait_idle("alun_idle");
        check("alun_wr_count", wr_cyc.size(), 0);
        check("alun_fun", at(en_fun, 0), 2);
        check("alun_tx_lo", at(tx_dat, 0), 'h15);
        check("alun_tx_hi", at(tx_dat, 1), 'h00);

        // burst write with address wrap
        clear_logs();
        send(8'hEE); send(8'h0E); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        wait_idle("bwr_idle");
        check("bwr_count", wr_cyc.size(), 3);
        check("bwr_w0", at(wr_adr, 0) * 256 + at(wr_dat, 0), 'h0E11);
        check("bwr_w1", at(wr_adr, 1) * 256 + at(wr_dat, 1), 'h0F22);
        check("bwr_w2", at(wr_adr, 2) * 256 + at(wr_dat, 2), 'h0033);

        // burst read with address wrap
        clear_logs();
        send(8'hEF); send(8'h0E); send(8'h03);
        wait_idle("brd_idle");
        check("brd_rd_count", rd_cyc.size(), 3);
        check("brd_tx_count", tx_cyc.size(), 3);
        check("brd_d0", at(tx_dat, 0), 'h11);
        check("brd_d1", at(tx_dat, 1), 'h22);
        check("brd_d2", at(tx_dat, 2), 'h33);
        check("brd_rd1_spacing", at(rd_cyc, 1), at(tx_cyc, 0) + 1);
        check("brd_rd2_spacing", at(rd_cyc, 2), at(tx_cyc, 1) + 1);

        // FIFO backpressure during a read
        clear_logs();
        FIFO_Full = 1'b1;
        send(8'hBB); send(8'h05);
        repeat (20) @(posedge CLK);
        #1;
        check("bp_no_push_while_full", tx_cyc.size(), 0);
        FIFO_Full = 1'b0;
        t_rel = cyc;
        wait_idle("bp_idle");
        check("bp_push_count", tx_cyc.size(), 1);
        check("bp_push_cycle", at(tx_cyc, 0), t_rel + 1);
        check("bp_push_data", at(tx_dat, 0), 'h3C);

        // unknown opcode
        clear_logs();
        send(8'h55);
        stb = last_stb;
        check("err_count", err_cyc.size(), 1);
        check("err_cycle", at(err_cyc, 0), stb + 1);
        check("err_busy_cycles", busy_cycles, 0);

        // burst count of zero
        clear_logs();
        send(8'hEE); send(8'h03); send(8'h00);
        wait_idle("n0_idle");
        check("n0_no_write", wr_cyc.size(), 0);
        check("n0_no_error", err_cyc.size(), 0);

        // reset in the middle of a write frame
        clear_logs();
        send(8'hAA); send(8'h07);
        RST = 1'b1;
        #2;
        check("midrst_busy", int'(busy), 0);
        check("midrst_clk_div_en", int'(clk_div_en), 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        check("midrst_no_strobes", wr_cyc.size() + rd_cyc.size() + tx_cyc.size() + err_cyc.size(), 0);
        check("midrst_idle", int'(busy), 0);

`ifdef SYS_CTRL_TIMEOUT_EN
        // partial frame abort
        clear_logs();
        send(8'hAA);
        stb = last_stb;
        for (int i = 0; i < 40 && err_cyc.size() == 0; i++) begin
            @(posedge CLK); #1;
        end
        repeat (2) @(posedge CLK);
        #1;
        check("tmo_err_count", err_cyc.size(), 1);
        check("tmo_err_cycle", at(err_cyc, 0), stb + TO + 1);
        check("tmo_idle", int'(busy), 0);
`endif

        check("no_push_while_full", full_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
